hazard_scoreboard: RTL and testbench

- Parametrised successor to the single-cycle load-use detector in the CPU pipeline; sits beside the ID stage.
- Tracks every in-flight register write whose result is not yet forwardable:
  - loads, with a fixed load-to-use latency;
  - long ops (div/mod), with variable latency, completing at writeback.
- Raises a decode stall for any RAW hazard on NSRC source ports and for any WAW hazard against a pending long op.
- Clears all state on pipeline flush.

---
 rtl/hazard_scoreboard_if.sv | 32 +++
 rtl/hazard_scoreboard.sv | 126 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode/writeback signal bundle between the ID stage and hazard_scoreboard
interface hazard_scoreboard_if #(
    parameter int NSRC = 2,
    parameter int RA_W = 5
) ();
    logic                 ds_valid;
    logic [NSRC-1:0]      ds_rf_ren;
    logic [NSRC*RA_W-1:0] ds_rf_raddr;
    logic [RA_W-1:0]      ds_dest;
    logic                 ds_load_op;
    logic                 ds_long_op;
    logic                 ds_issue;
    logic                 long_done;
    logic [RA_W-1:0]      long_done_dest;
    logic                 flush;
    logic                 ds_stall;
    logic                 busy_any;

    // Pipeline side: drives decode/writeback events, receives the stall.
    modport master (
        output ds_valid, ds_rf_ren, ds_rf_raddr, ds_dest, ds_load_op, ds_long_op,
        output ds_issue, long_done, long_done_dest, flush,
        input  ds_stall, busy_any
    );

    // Scoreboard side.
    modport slave (
        input  ds_valid, ds_rf_ren, ds_rf_raddr, ds_dest, ds_load_op, ds_long_op,
        input  ds_issue, long_done, long_done_dest, flush,
        output ds_stall, busy_any
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - RAW/WAW decode-stall scoreboard for loads and long ops; HAZARD_STALL_CNT_EN adds stall_cnt
module hazard_scoreboard #(
    parameter int NSRC     = 2,
    parameter int NREG     = 32,
    parameter int RA_W     = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 3
) (
    input  logic               clk,
    input  logic               resetn,
    hazard_scoreboard_if.slave bus
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0]        stall_cnt
`endif
);
    // Register 0 has no storage: arrays start at index 1 and the lookup
    // vectors below splice in a constant idle entry for r0.
    logic [CNT_W-1:0] cnt_q [1:NREG-1];
    logic [CNT_W-1:0] cnt_d [1:NREG-1];
    logic [NREG-1:1]  lbusy_q;
    logic [NREG-1:1]  lbusy_d;
    logic [NREG-1:1]  cnt_nz;
    logic [NREG-1:0]  cnt_vis;
    logic [NREG-1:0]  lb_vis;
    logic             raw_hit;
    logic             waw_hit;
    logic             stall;
    logic             issue_eff;
    logic             busy_d;
    logic             busy_q;

    // Load countdown nonzero flags, one per real register.
    always_comb begin
        for (int r = 1; r < NREG; r++) begin
            cnt_nz[r] = (cnt_q[r] != '0);
        end
    end

    assign cnt_vis = {cnt_nz, 1'b0};
    assign lb_vis  = {lbusy_q, 1'b0};

    // RAW check over every enabled source port.
    always_comb begin
        raw_hit = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (bus.ds_rf_ren[i] &&
                (cnt_vis[bus.ds_rf_raddr[i*RA_W +: RA_W]] ||
                 lb_vis[bus.ds_rf_raddr[i*RA_W +: RA_W]])) begin
                raw_hit = 1'b1;
            end
        end
    end

    // A new writer must not overtake a pending long op on the same register.
    assign waw_hit      = lb_vis[bus.ds_dest];
    assign stall        = bus.ds_valid & (raw_hit | waw_hit);
    assign bus.ds_stall = stall;

    // A stalled issue request is ignored; r0 writes are never tracked.
    assign issue_eff = bus.ds_issue & ~stall & (bus.ds_dest != '0);

    // Next state: decrement, long completion, then issue overrides, flush wins.
    always_comb begin
        for (int r = 1; r < NREG; r++) begin
            cnt_d[r]   = (cnt_q[r] != '0) ? (cnt_q[r] - CNT_W'(1)) : '0;
            lbusy_d[r] = lbusy_q[r] &
                         ~(bus.long_done && (bus.long_done_dest == RA_W'(r)));
            if (issue_eff && (bus.ds_dest == RA_W'(r))) begin
                if (bus.ds_load_op) begin
                    cnt_d[r] = CNT_W'(LOAD_LAT);
                end else if (bus.ds_long_op) begin
                    lbusy_d[r] = 1'b1;
                    cnt_d[r]   = '0;
                end else begin
                    // Younger ALU writer forwards; the older load is shadowed.
                    cnt_d[r] = '0;
                end
            end
            if (bus.flush) begin
                cnt_d[r]   = '0;
                lbusy_d[r] = 1'b0;
            end
        end
    end

    // Summary of post-update occupancy, registered into busy_any.
    always_comb begin
        busy_d = |lbusy_d;
        for (int r = 1; r < NREG; r++) begin
            if (cnt_d[r] != '0) begin
                busy_d = 1'b1;
            end
        end
    end

    // Scoreboard state; asynchronous reset drops every pending hazard at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 1; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            lbusy_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            lbusy_q <= lbusy_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.busy_any = busy_q;

`ifdef HAZARD_STALL_CNT_EN
    // Saturating count of stalled decode cycles; flush leaves it untouched.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench for hazard_scoreboard with LOAD_LAT=1 and LOAD_LAT=3 instances
module tb_hazard_scoreboard;
    localparam int NSRC = 2;
    localparam int NREG = 32;
    localparam int RA_W = 5;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NSRC(NSRC), .RA_W(RA_W)) bus_a ();
    hazard_scoreboard_if #(.NSRC(NSRC), .RA_W(RA_W)) bus_b ();

    assign bus_b.ds_valid       = bus_a.ds_valid;
    assign bus_b.ds_rf_ren      = bus_a.ds_rf_ren;
    assign bus_b.ds_rf_raddr    = bus_a.ds_rf_raddr;
    assign bus_b.ds_dest        = bus_a.ds_dest;
    assign bus_b.ds_load_op     = bus_a.ds_load_op;
    assign bus_b.ds_long_op     = bus_a.ds_long_op;
    assign bus_b.ds_issue       = bus_a.ds_issue;
    assign bus_b.long_done      = bus_a.long_done;
    assign bus_b.long_done_dest = bus_a.long_done_dest;
    assign bus_b.flush          = bus_a.flush;

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_a;
    logic [31:0] stall_cnt_b;
`endif

    hazard_scoreboard #(.NSRC(NSRC), .NREG(NREG), .RA_W(RA_W), .LOAD_LAT(1), .CNT_W(3)) dut_a (
        .clk(clk), .resetn(resetn), .bus(bus_a)
`ifdef HAZARD_STALL_CNT_EN
        , .stall_cnt(stall_cnt_a)
`endif
    );

    hazard_scoreboard #(.NSRC(NSRC), .NREG(NREG), .RA_W(RA_W), .LOAD_LAT(3), .CNT_W(3)) dut_b (
        .clk(clk), .resetn(resetn), .bus(bus_b)
`ifdef HAZARD_STALL_CNT_EN
        , .stall_cnt(stall_cnt_b)
`endif
    );

    // Reference model: a load to r issued in cycle t makes r unreadable until
    // cycle t+L+1 (absolute ready time); long ops hold a busy flag until done.
    int  rdy [2][NREG];
    bit  lb  [2][NREG];
    int  cyc = 0;
    int  exp_cnt [2];

    typedef struct packed {
        logic [1:0] stall;
        logic [1:0] busy;
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;

    int checks = 0;
    int failures = 0;

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic bit m_pending(input int k, input int r);
        return (r != 0) && ((rdy[k][r] > cyc) || lb[k][r]);
    endfunction

    function automatic bit m_busy(input int k);
        for (int r = 1; r < NREG; r++) begin
            if ((rdy[k][r] > cyc) || lb[k][r]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < NREG; r++) begin
                rdy[k][r] = 0;
                lb[k][r]  = 1'b0;
            end
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic drive_idle();
        bus_a.ds_valid       = 1'b0;
        bus_a.ds_rf_ren      = '0;
        bus_a.ds_rf_raddr    = '0;
        bus_a.ds_dest        = '0;
        bus_a.ds_load_op     = 1'b0;
        bus_a.ds_long_op     = 1'b0;
        bus_a.ds_issue       = 1'b0;
        bus_a.long_done      = 1'b0;
        bus_a.long_done_dest = '0;
        bus_a.flush          = 1'b0;
    endtask

    // One decode cycle: drive, predict both instances, advance the model.
    task automatic step(input bit v, input bit [1:0] ren, input int a0, input int a1,
                        input int dst, input bit ld, input bit lg, input bit iss,
                        input bit dn, input int dd, input bit fl);
        exp_t e;
        bit   st;
        @(posedge clk);
        #1;
        bus_a.ds_valid       = v;
        bus_a.ds_rf_ren      = ren;
        bus_a.ds_rf_raddr    = {a1[RA_W-1:0], a0[RA_W-1:0]};
        bus_a.ds_dest        = dst[RA_W-1:0];
        bus_a.ds_load_op     = ld;
        bus_a.ds_long_op     = lg;
        bus_a.ds_issue       = iss;
        bus_a.long_done      = dn;
        bus_a.long_done_dest = dd[RA_W-1:0];
        bus_a.flush          = fl;
        for (int k = 0; k < 2; k++) begin
            st = v && ((ren[0] && m_pending(k, a0)) || (ren[1] && m_pending(k, a1)) ||
                       (dst != 0 && lb[k][dst]));
            e.stall[k] = st;
            e.busy[k]  = m_busy(k);
            if (st) exp_cnt[k]++;
            if (fl) begin
                for (int r = 0; r < NREG; r++) begin
                    rdy[k][r] = 0;
                    lb[k][r]  = 1'b0;
                end
            end else begin
                if (dn && dd != 0) lb[k][dd] = 1'b0;
                if (iss && !st && dst != 0) begin
                    if (ld) begin
                        rdy[k][dst] = cyc + lat(k) + 1;
                    end else if (lg) begin
                        lb[k][dst]  = 1'b1;
                        rdy[k][dst] = 0;
                    end else begin
                        rdy[k][dst] = 0;
                    end
                end
            end
        end
        sb.push_back(e);
        cyc++;
    endtask

    task automatic rd(input int a0, input int a1, input bit [1:0] ren);
        step(1, ren, a0, a1, 0, 0, 0, 1, 0, 0, 0);
    endtask

    // Monitor: compares whatever the stimulus predicted for this cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("stall_l1", {31'd0, bus_a.ds_stall}, {31'd0, mon_e.stall[0]});
            check("stall_l3", {31'd0, bus_b.ds_stall}, {31'd0, mon_e.stall[1]});
            check("busy_l1",  {31'd0, bus_a.busy_any}, {31'd0, mon_e.busy[0]});
            check("busy_l3",  {31'd0, bus_b.busy_any}, {31'd0, mon_e.busy[1]});
        end
    end

    initial begin
        bit       v, iss, ld, lg, dn, fl;
        bit [1:0] ren;
        int       a0, a1, dst, dd, kind;

        drive_idle();
        model_clear();
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        #1;
        check("rst_stall_l1", {31'd0, bus_a.ds_stall}, 32'd0);
        check("rst_busy_l1",  {31'd0, bus_a.busy_any}, 32'd0);
        check("rst_stall_l3", {31'd0, bus_b.ds_stall}, 32'd0);
        check("rst_busy_l3",  {31'd0, bus_b.busy_any}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;

        // Load r5 then readers on port 0; then a load with r0 reader.
        step(1, 2'b00, 0, 0, 5, 1, 0, 1, 0, 0, 0);
        repeat (5) rd(5, 0, 2'b01);
        step(1, 2'b00, 0, 0, 5, 1, 0, 1, 0, 0, 0);
        repeat (3) rd(0, 0, 2'b11);
        // Load r7, reader on port 1, then port 1 disabled.
        step(1, 2'b00, 0, 0, 7, 1, 0, 1, 0, 0, 0);
        repeat (5) rd(0, 7, 2'b10);
        step(1, 2'b00, 0, 0, 7, 1, 0, 1, 0, 0, 0);
        repeat (3) rd(0, 7, 2'b01);
        // div r9, held reader, stray done r10, WAW writer, then done r9.
        step(1, 2'b00, 0, 0, 9, 0, 1, 1, 0, 0, 0);
        repeat (20) rd(9, 0, 2'b01);
        step(1, 2'b01, 9, 0, 0, 0, 0, 1, 1, 10, 0);
        repeat (3) step(1, 2'b00, 0, 0, 9, 0, 0, 1, 0, 0, 0);
        step(1, 2'b01, 9, 0, 0, 0, 0, 1, 1, 9, 0);
        repeat (2) rd(9, 0, 2'b01);
        // Load r4 shadowed by ALU write to r4.
        step(1, 2'b00, 0, 0, 4, 1, 0, 1, 0, 0, 0);
        step(1, 2'b00, 0, 0, 4, 0, 0, 1, 0, 0, 0);
        repeat (3) rd(4, 4, 2'b11);
        // Load r6 and div r8, then flush.
        step(1, 2'b00, 0, 0, 6, 1, 0, 1, 0, 0, 0);
        step(1, 2'b00, 0, 0, 8, 0, 1, 1, 0, 0, 0);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (3) rd(6, 8, 2'b11);

        // Asynchronous reset in the middle of a stall.
        step(1, 2'b00, 0, 0, 5, 1, 0, 1, 0, 0, 0);
        rd(5, 0, 2'b01);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_stall_l1", {31'd0, bus_a.ds_stall}, 32'd0);
        check("arst_stall_l3", {31'd0, bus_b.ds_stall}, 32'd0);
        check("arst_busy_l1",  {31'd0, bus_a.busy_any}, 32'd0);
        check("arst_busy_l3",  {31'd0, bus_b.busy_any}, 32'd0);
`ifdef HAZARD_STALL_CNT_EN
        check("arst_stall_cnt_l1", stall_cnt_a, 32'd0);
        check("arst_stall_cnt_l3", stall_cnt_b, 32'd0);
`endif
        model_clear();
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        drive_idle();
        @(posedge clk);
        cyc++;
        #1;
        resetn = 1'b1;

        // Randomized traffic over a small register window to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            v    = ($urandom_range(0, 9) != 0);
            ren  = 2'($urandom_range(0, 3));
            a0   = $urandom_range(0, 7);
            a1   = $urandom_range(0, 7);
            dst  = $urandom_range(0, 7);
            kind = $urandom_range(0, 9);
            ld   = (kind < 3);
            lg   = (kind == 3);
            iss  = v && ($urandom_range(0, 9) < 8);
            dn   = ($urandom_range(0, 5) == 0);
            dd   = $urandom_range(0, 7);
            fl   = ($urandom_range(0, 39) == 0);
            step(v, ren, a0, a1, dst, ld, lg, iss, dn, dd, fl);
        end

        @(posedge clk);
        #1;
`ifdef HAZARD_STALL_CNT_EN
        check("stall_cnt_l1", stall_cnt_a, 32'(exp_cnt[0]));
        check("stall_cnt_l3", stall_cnt_b, 32'(exp_cnt[1]));
`endif
        drive_idle();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
